// File: rtl/irq_coalescer_pkg.sv
// irq_coalescer_pkg: shared channel state type for the interrupt coalescer
package irq_coalescer_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, HOLD} coal_state_t;
endpackage

// File: rtl/irq_coalesce_channel.sv
// irq_coalesce_channel: one channel's batch FSM, saturating counter, timeout timer and last_count
// Ports: clk/reset_n clock and async active-low reset; event_in/chan_en strobe and enable;
// threshold/timeout shared batch controls; irq_out batch pulse; last_count size of last batch.
module irq_coalesce_channel
  import irq_coalescer_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int TMR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 event_in,
  input  logic                 chan_en,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic [TMR_WIDTH-1:0] timeout,
  output logic                 irq_out,
  output logic [CNT_WIDTH-1:0] last_count
);
  coal_state_t          r_state;
  coal_state_t          w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [TMR_WIDTH-1:0] r_tmr;
  logic [CNT_WIDTH-1:0] r_last;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_thr;
  logic                 w_ev;
  logic                 w_hit;
  logic                 w_tmo;
  logic                 w_fire;
  assign w_ev      = event_in & chan_en;
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(w_ev);
  assign w_thr     = (threshold == '0) ? CNT_WIDTH'(1) : threshold;
  assign w_hit     = w_cnt_nxt >= w_thr;
  assign w_tmo     = (timeout != '0) && (r_tmr == timeout - TMR_WIDTH'(1));
  // FIRE never re-fires; only ACCUM honours the timeout, other states fire on count alone
  assign w_fire    = chan_en && (r_state == ACCUM ? (w_hit || w_tmo) : (r_state != FIRE) && w_hit);
  always_comb begin
    w_state_nxt = !chan_en ? IDLE :
                  w_fire ? FIRE :
                  (r_state == FIRE) ? HOLD :
                  (w_cnt_nxt != '0) ? ACCUM : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (!chan_en || w_fire) ? '0 : w_cnt_nxt;
      r_tmr   <= (r_state == ACCUM && w_state_nxt == ACCUM) ? r_tmr + TMR_WIDTH'(1) : '0;
      r_last  <= w_fire ? w_cnt_nxt : r_last;
    end
  end
  assign irq_out    = (r_state == FIRE);
  assign last_count = r_last;
endmodule

// File: rtl/irq_coalescer.sv
// irq_coalescer: per-source event coalescer emitting one spaced pulse per batch
// Ports: clk/reset_n clock and async active-low reset; event_in/chan_en per-channel strobes and
// enables; threshold/timeout shared controls; irq_out pulses; last_count flattened batch sizes.
module irq_coalescer #(
  parameter int NUM_SOURCES = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int TMR_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_SOURCES-1:0]           event_in,
  input  logic [NUM_SOURCES-1:0]           chan_en,
  input  logic [CNT_WIDTH-1:0]             threshold,
  input  logic [TMR_WIDTH-1:0]             timeout,
  output logic [NUM_SOURCES-1:0]           irq_out,
  output logic [NUM_SOURCES*CNT_WIDTH-1:0] last_count
);
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_ch
    irq_coalesce_channel #(.CNT_WIDTH(CNT_WIDTH), .TMR_WIDTH(TMR_WIDTH)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .event_in   (event_in[i]),
      .chan_en    (chan_en[i]),
      .threshold  (threshold),
      .timeout    (timeout),
      .irq_out    (irq_out[i]),
      .last_count (last_count[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule

// File: tb/tb_irq_coalescer.sv
// tb_irq_coalescer: randomized and directed checks of irq_coalescer against a timestamp model
module tb_irq_coalescer;
  localparam int NS   = 8;
  localparam int CW   = 4;
  localparam int TW   = 16;
  localparam int CMAX = (1 << CW) - 1;
  logic           clk = 0;
  logic           reset_n = 0;
  logic [NS-1:0]  event_in = '0;
  logic [NS-1:0]  chan_en = '0;
  logic [CW-1:0]  threshold = '0;
  logic [TW-1:0]  timeout = '0;
  logic [NS-1:0]  irq_out;
  logic [NS*CW-1:0] last_count;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int m_p[NS];
  int m_open[NS];
  int m_last[NS];
  bit m_pulse[NS];
  always #5 clk = ~clk;
  irq_coalescer #(.NUM_SOURCES(NS), .CNT_WIDTH(CW), .TMR_WIDTH(TW)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .event_in   (event_in),
    .chan_en    (chan_en),
    .threshold  (threshold),
    .timeout    (timeout),
    .irq_out    (irq_out),
    .last_count (last_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [63:0] exp_irq();
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++) v[i] = m_pulse[i];
    return v;
  endfunction
  function automatic logic [63:0] exp_last();
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++) v[i*CW +: CW] = CW'(m_last[i]);
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_p[i] = 0;
      m_open[i] = 0;
      m_last[i] = 0;
      m_pulse[i] = 0;
    end
  endtask
  // A batch "opens" at the cycle its first event is seen outside a pulse (or the cycle after a
  // pulse that caught one); it times out when tmo cycles have elapsed since the cycle after opening.
  task automatic step(input logic [NS-1:0] ev, input logic [NS-1:0] en, input int thr, input int tmo);
    bit np;
    int pn, te, age;
    @(negedge clk);
    chk("irq_out", 64'(irq_out), exp_irq());
    chk("last_count", 64'(last_count), exp_last());
    event_in  = ev;
    chan_en   = en;
    threshold = CW'(thr);
    timeout   = TW'(tmo);
    for (int i = 0; i < NS; i++) begin
      np = 0;
      if (!en[i]) m_p[i] = 0;
      else begin
        pn = m_p[i] + int'(ev[i]);
        if (pn > CMAX) pn = CMAX;
        if (m_pulse[i]) begin
          if (pn > 0) m_open[i] = cyc + 1;
          m_p[i] = pn;
        end else begin
          te  = (thr < 1) ? 1 : thr;
          age = (cyc - m_open[i] - 1) & ((1 << TW) - 1);
          if (pn >= te || (tmo != 0 && m_p[i] > 0 && age == tmo - 1)) begin
            np = 1;
            m_last[i] = pn;
            m_p[i] = 0;
          end else begin
            if (m_p[i] == 0 && pn > 0) m_open[i] = cyc;
            m_p[i] = pn;
          end
        end
      end
      m_pulse[i] = np;
    end
    cyc++;
  endtask
  task automatic idle(input int n, input int thr, input int tmo);
    for (int k = 0; k < n; k++) step('0, '1, thr, tmo);
  endtask
  initial begin
    logic [NS-1:0] ev, en;
    int thr, tmo, dens;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1;
    idle(3, 4, 0);
    for (int k = 0; k < 4; k++) step(8'h04, '1, 4, 0);
    idle(4, 4, 0);
    step(8'h01, '1, 8, 5);
    idle(8, 8, 5);
    for (int k = 0; k < 6; k++) step(8'h02, '1, 1, 0);
    idle(4, 1, 0);
    step(8'h08, '1, 4, 0);
    step(8'h08, '1, 4, 0);
    for (int k = 0; k < 4; k++) step(8'h08, 8'hF7, 4, 0);
    idle(2, 4, 0);
    for (int k = 0; k < 4; k++) step(8'h08, '1, 4, 0);
    idle(3, 4, 0);
    step(8'h60, '1, 15, 6);
    for (int k = 0; k < 19; k++) step(8'h20, '1, 15, 6);
    idle(10, 15, 6);
    for (int k = 0; k < 3; k++) step(8'h01, '1, 4, 0);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("rst_irq", 64'(irq_out), 64'h0);
    chk("rst_last", 64'(last_count), 64'h0);
    model_reset();
    event_in = '0;
    @(negedge clk);
    reset_n = 1;
    cyc++;
    step(8'h01, '1, 4, 5);
    idle(9, 4, 5);
    for (int ph = 0; ph < 25; ph++) begin
      thr  = $urandom_range(0, 8);
      tmo  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 10);
      dens = $urandom_range(0, 4);
      for (int k = 0; k < 120; k++) begin
        for (int b = 0; b < NS; b++) ev[b] = ($urandom_range(0, dens) == 0);
        en = (ph % 4 == 3 && $urandom_range(0, 7) == 0) ? NS'($urandom) : '1;
        step(ev, en, thr, tmo);
      end
    end
    idle(12, 1, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
